// File: rtl/fpnew_result_sink.sv
// Result sink for the FP16 FPU output port: buffers result/status/tag in a small
// FIFO, accumulates sticky exception flags and counts accepted and NaN results.
module fpnew_result_sink #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] res_i,
   input  logic [4:0]       status_i,
   input  logic             tag_i,
   input  logic             res_valid_i,
   output logic             res_ready_o,
   output logic [WIDTH-1:0] out_data_o,
   output logic [4:0]       out_status_o,
   output logic             out_tag_o,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   input  logic             clear_flags_i,
   output logic [4:0]       fflags_o,
   output logic [CNT_W-1:0] res_count_o,
   output logic [CNT_W-1:0] nan_count_o,
   output logic             full_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem_data   [DEPTH];
   logic [4:0]       r_mem_status [DEPTH];
   logic             r_mem_tag    [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_occ;
   logic [4:0]       r_fflags;
   logic [CNT_W-1:0] r_res_count;
   logic [CNT_W-1:0] r_nan_count;

   logic w_ready;
   logic w_push;
   logic w_pop;
   logic w_is_nan;

   // Ready looks only at occupancy, so a pop in a full cycle never admits a push.
   assign w_ready  = !rst_i && (r_occ < FULL_OCC);
   assign w_push   = res_valid_i && w_ready;
   assign w_pop    = (r_occ != '0) && out_ready_i;
   assign w_is_nan = (res_i[14:10] == 5'h1F) && (res_i[9:0] != 10'd0);

   assign res_ready_o  = w_ready;
   assign out_valid_o  = (r_occ != '0);
   assign out_data_o   = r_mem_data[r_rd_ptr];
   assign out_status_o = r_mem_status[r_rd_ptr];
   assign out_tag_o    = r_mem_tag[r_rd_ptr];
   assign full_o       = (r_occ == FULL_OCC);
   assign fflags_o     = r_fflags;
   assign res_count_o  = r_res_count;
   assign nan_count_o  = r_nan_count;

   // Storage needs no reset: an entry is only readable after it was written.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem_data[r_wr_ptr]   <= res_i;
         r_mem_status[r_wr_ptr] <= status_i;
         r_mem_tag[r_wr_ptr]    <= tag_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_occ       <= '0;
         r_fflags    <= '0;
         r_res_count <= '0;
         r_nan_count <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + 1'b1;
            2'b01:   r_occ <= r_occ - 1'b1;
            default: r_occ <= r_occ;
         endcase
         if (w_push)
            r_fflags <= (clear_flags_i ? 5'd0 : r_fflags) | status_i;
         else if (clear_flags_i)
            r_fflags <= 5'd0;
         if (w_push && (r_res_count != '1))
            r_res_count <= r_res_count + 1'b1;
         if (w_push && w_is_nan && (r_nan_count != '1))
            r_nan_count <= r_nan_count + 1'b1;
      end
   end

endmodule
